// File: rtl/imm_gen_pipe.sv
`timescale 1ns/1ps
// Registered RISC-V immediate decoder feeding a 2-entry valid/ready skid queue with a side-band tag.
// Optional macro IMM_ZICSR_EN: CSR immediate forms emit the zero-extended uimm with format 6.
module imm_gen_pipe #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_inst,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic             out_unknown,
  output logic [TAG_W-1:0] out_tag
);

  localparam logic [6:0] OpOpImm   = 7'b0010011;
  localparam logic [6:0] OpLoad    = 7'b0000011;
  localparam logic [6:0] OpJalr    = 7'b1100111;
  localparam logic [6:0] OpOpImm32 = 7'b0011011;
  localparam logic [6:0] OpStore   = 7'b0100011;
  localparam logic [6:0] OpBranch  = 7'b1100011;
  localparam logic [6:0] OpAuipc   = 7'b0010111;
  localparam logic [6:0] OpLui     = 7'b0110111;
  localparam logic [6:0] OpJal     = 7'b1101111;
  localparam logic [6:0] OpOp      = 7'b0110011;
  localparam logic [6:0] OpMiscMem = 7'b0001111;
  localparam logic [6:0] OpSystem  = 7'b1110011;
  localparam logic [6:0] OpOp32    = 7'b0111011;

  localparam logic [2:0] FmtNone = 3'd0;
  localparam logic [2:0] FmtI    = 3'd1;
  localparam logic [2:0] FmtS    = 3'd2;
  localparam logic [2:0] FmtB    = 3'd3;
  localparam logic [2:0] FmtU    = 3'd4;
  localparam logic [2:0] FmtJ    = 3'd5;
`ifdef IMM_ZICSR_EN
  localparam logic [2:0] FmtCsr  = 3'd6;
`endif

  localparam bit Rv64 = (XLEN == 64);

  // ---------------------------------------------------------------------------
  // Decode
  // ---------------------------------------------------------------------------
  logic [6:0]         opcode;
  logic signed [11:0] imm_i;
  logic signed [11:0] imm_s;
  logic signed [12:0] imm_b;
  logic signed [31:0] imm_u;
  logic signed [20:0] imm_j;

  assign opcode = in_inst[6:0];
  assign imm_i  = in_inst[31:20];
  assign imm_s  = {in_inst[31:25], in_inst[11:7]};
  assign imm_b  = {in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
  assign imm_u  = {in_inst[31:12], 12'b0};
  assign imm_j  = {in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};

  logic [XLEN-1:0] dec_imm;
  logic [2:0]      dec_fmt;
  logic            dec_unknown;

  // Size casts of signed fields sign-extend to XLEN.
  always_comb begin
    dec_imm     = '0;
    dec_fmt     = FmtNone;
    dec_unknown = 1'b0;
    case (opcode)
      OpOpImm, OpLoad, OpJalr: begin
        dec_imm = XLEN'(imm_i);
        dec_fmt = FmtI;
      end
      OpOpImm32: begin
        if (Rv64) begin
          dec_imm = XLEN'(imm_i);
          dec_fmt = FmtI;
        end else begin
          dec_unknown = 1'b1;
        end
      end
      OpStore: begin
        dec_imm = XLEN'(imm_s);
        dec_fmt = FmtS;
      end
      OpBranch: begin
        dec_imm = XLEN'(imm_b);
        dec_fmt = FmtB;
      end
      OpAuipc, OpLui: begin
        dec_imm = XLEN'(imm_u);
        dec_fmt = FmtU;
      end
      OpJal: begin
        dec_imm = XLEN'(imm_j);
        dec_fmt = FmtJ;
      end
      OpOp, OpMiscMem: begin
        dec_fmt = FmtNone;
      end
      OpOp32: begin
        dec_unknown = !Rv64;
      end
      OpSystem: begin
`ifdef IMM_ZICSR_EN
        if (in_inst[14]) begin
          dec_imm = XLEN'(in_inst[19:15]);
          dec_fmt = FmtCsr;
        end
`endif
      end
      default: begin
        dec_unknown = 1'b1;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Two-entry circular queue
  // ---------------------------------------------------------------------------
  logic [XLEN-1:0]  imm_q [2];
  logic [2:0]       fmt_q [2];
  logic             unk_q [2];
  logic [TAG_W-1:0] tag_q [2];

  logic       wr_ptr_q, wr_ptr_d;
  logic       rd_ptr_q, rd_ptr_d;
  logic [1:0] count_q, count_d;
  logic       push, pop;

  assign in_ready  = reset_n & (count_q < 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign push      = in_valid & in_ready & ~flush;
  assign pop       = out_valid & out_ready;

  // Flush wins over push and pop; storage keeps its contents.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (push) wr_ptr_d = ~wr_ptr_q;
      if (pop)  rd_ptr_d = ~rd_ptr_q;
      case ({push, pop})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        imm_q[i] <= '0;
        fmt_q[i] <= '0;
        unk_q[i] <= 1'b0;
        tag_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push) begin
        imm_q[wr_ptr_q] <= dec_imm;
        fmt_q[wr_ptr_q] <= dec_fmt;
        unk_q[wr_ptr_q] <= dec_unknown;
        tag_q[wr_ptr_q] <= in_tag;
      end
    end
  end

  assign out_imm     = imm_q[rd_ptr_q];
  assign out_fmt     = fmt_q[rd_ptr_q];
  assign out_unknown = unk_q[rd_ptr_q];
  assign out_tag     = tag_q[rd_ptr_q];

endmodule

// File: tb/tb_imm_gen_pipe.sv
`timescale 1ns/1ps
// Bench for imm_gen_pipe: directed vector tables (XLEN 32 and 64), queue corner sequences,
// and randomized traffic against a queue-based reference model.
module tb_imm_gen_pipe;

  typedef struct {
    logic [31:0] inst;
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic        unk;
  } vec_t;

  typedef struct {
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic        unk;
    logic [31:0] tag;
  } ent_t;

`ifdef IMM_ZICSR_EN
  localparam logic [63:0] CsrImm = 64'd5;
  localparam logic [2:0]  CsrFmt = 3'd6;
`else
  localparam logic [63:0] CsrImm = 64'd0;
  localparam logic [2:0]  CsrFmt = 3'd0;
`endif

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset_n, flush, in_valid, out_ready;
  logic [31:0] in_inst, in_tag;
  logic        in_ready, out_valid, out_unknown;
  logic [31:0] out_imm, out_tag;
  logic [2:0]  out_fmt;

  logic        flush64, in_valid64, out_ready64;
  logic [31:0] in_inst64;
  logic [7:0]  in_tag64, out_tag64;
  logic        in_ready64, out_valid64, out_unknown64;
  logic [63:0] out_imm64;
  logic [2:0]  out_fmt64;

  imm_gen_pipe #(.XLEN(32), .TAG_W(32)) u_dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_inst     (in_inst),
    .in_tag      (in_tag),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_imm     (out_imm),
    .out_fmt     (out_fmt),
    .out_unknown (out_unknown),
    .out_tag     (out_tag)
  );

  imm_gen_pipe #(.XLEN(64), .TAG_W(8)) u_dut64 (
    .clock       (clock),
    .reset_n     (reset_n),
    .flush       (flush64),
    .in_valid    (in_valid64),
    .in_ready    (in_ready64),
    .in_inst     (in_inst64),
    .in_tag      (in_tag64),
    .out_valid   (out_valid64),
    .out_ready   (out_ready64),
    .out_imm     (out_imm64),
    .out_fmt     (out_fmt64),
    .out_unknown (out_unknown64),
    .out_tag     (out_tag64)
  );

  int   n_pass  = 0;
  int   n_total = 0;
  ent_t mq[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
  endtask

  // Reference decode from the instruction-format rules: assemble the field value
  // arithmetically, then reinterpret it as a two's-complement number of nb bits.
  function automatic ent_t ref_decode(input logic [31:0] inst, input logic [31:0] tag);
    ent_t   e;
    longint v;
    int     nb;
    e.tag = tag;
    e.fmt = 3'd0;
    e.unk = 1'b0;
    v     = 0;
    nb    = 0;
    case (inst[6:0])
      7'h13, 7'h03, 7'h67: begin v = inst[31:20]; nb = 12; e.fmt = 3'd1; end
      7'h23: begin v = inst[31:25] * 32 + inst[11:7]; nb = 12; e.fmt = 3'd2; end
      7'h63: begin
        v  = inst[31] * 4096 + inst[7] * 2048 + inst[30:25] * 32 + inst[11:8] * 2;
        nb = 13; e.fmt = 3'd3;
      end
      7'h17, 7'h37: begin v = inst[31:12] * 4096; nb = 32; e.fmt = 3'd4; end
      7'h6F: begin
        v  = inst[31] * 1048576 + inst[19:12] * 4096 + inst[20] * 2048 + inst[30:21] * 2;
        nb = 21; e.fmt = 3'd5;
      end
      7'h33, 7'h0F: ;
      7'h73: begin
`ifdef IMM_ZICSR_EN
        if (inst[14]) begin v = inst[19:15]; e.fmt = 3'd6; end
`endif
      end
      default: e.unk = 1'b1;
    endcase
    if (nb != 0 && v >= (longint'(1) << (nb - 1))) v = v - (longint'(1) << nb);
    e.imm = v;
    return e;
  endfunction

  // One clock of the 32-bit DUT: drive at the falling edge, check against the model,
  // then advance the model with the handshakes that fire on the rising edge.
  task automatic cyc(input logic v, input logic [31:0] inst, input logic [31:0] tag,
                     input logic ordy, input logic fl);
    ent_t h;
    bit   do_push, do_pop;
    in_valid = v; in_inst = inst; in_tag = tag; out_ready = ordy; flush = fl;
    #1;
    chk("in_ready", in_ready, mq.size() < 2);
    chk("out_valid", out_valid, mq.size() != 0);
    if (mq.size() != 0) begin
      h = mq[0];
      chk("head_imm", out_imm, h.imm[31:0]);
      chk("head_fmt", out_fmt, h.fmt);
      chk("head_unknown", out_unknown, h.unk);
      chk("head_tag", out_tag, h.tag);
    end
    do_push = v && (mq.size() < 2);
    do_pop  = (mq.size() != 0) && ordy;
    @(posedge clock);
    if (fl) mq.delete();
    else begin
      if (do_pop) void'(mq.pop_front());
      if (do_push) mq.push_back(ref_decode(inst, tag));
    end
    @(negedge clock);
  endtask

  vec_t       tv32[17];
  vec_t       tv64[7];
  logic [6:0] ops[15];

  initial begin
    tv32[0]  = '{32'hFFF00093, 64'hFFFFFFFF, 3'd1, 1'b0};
    tv32[1]  = '{32'hFE112E23, 64'hFFFFFFFC, 3'd2, 1'b0};
    tv32[2]  = '{32'hFE000CE3, 64'hFFFFFFF8, 3'd3, 1'b0};
    tv32[3]  = '{32'h800000B7, 64'h80000000, 3'd4, 1'b0};
    tv32[4]  = '{32'h12345017, 64'h12345000, 3'd4, 1'b0};
    tv32[5]  = '{32'h0000006F, 64'h0,        3'd5, 1'b0};
    tv32[6]  = '{32'h0080006F, 64'h8,        3'd5, 1'b0};
    tv32[7]  = '{32'hFFFFF06F, 64'hFFFFFFFE, 3'd5, 1'b0};
    tv32[8]  = '{32'h00412083, 64'h4,        3'd1, 1'b0};
    tv32[9]  = '{32'h000080E7, 64'h0,        3'd1, 1'b0};
    tv32[10] = '{32'h00208463, 64'h8,        3'd3, 1'b0};
    tv32[11] = '{32'h002081B3, 64'h0,        3'd0, 1'b0};
    tv32[12] = '{32'h0FF0000F, 64'h0,        3'd0, 1'b0};
    tv32[13] = '{32'h0000007B, 64'h0,        3'd0, 1'b1};
    tv32[14] = '{32'h0000003B, 64'h0,        3'd0, 1'b1};
    tv32[15] = '{32'h3002D073, CsrImm,       CsrFmt, 1'b0};
    tv32[16] = '{32'h00000073, 64'h0,        3'd0, 1'b0};

    tv64[0] = '{32'h800000B7, 64'hFFFFFFFF80000000, 3'd4, 1'b0};
    tv64[1] = '{32'h0000006F, 64'h0,                3'd5, 1'b0};
    tv64[2] = '{32'h0000007B, 64'h0,                3'd0, 1'b1};
    tv64[3] = '{32'hFFF0009B, 64'hFFFFFFFFFFFFFFFF, 3'd1, 1'b0};
    tv64[4] = '{32'h0000003B, 64'h0,                3'd0, 1'b0};
    tv64[5] = '{32'hFE000CE3, 64'hFFFFFFFFFFFFFFF8, 3'd3, 1'b0};
    tv64[6] = '{32'hFFFFF06F, 64'hFFFFFFFFFFFFFFFE, 3'd5, 1'b0};

    ops = '{7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h17, 7'h37, 7'h6F,
            7'h33, 7'h0F, 7'h73, 7'h1B, 7'h3B, 7'h7B, 7'h00};

    reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_inst = '0; in_tag = '0;
    flush64 = 1'b0; in_valid64 = 1'b0; out_ready64 = 1'b0; in_inst64 = '0; in_tag64 = '0;

    // Reset state
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_imm", out_imm, 32'h0);
    chk("rst_out_fmt", out_fmt, 3'd0);
    chk("rst_out_tag", out_tag, 32'h0);
    chk("rst_out_unknown", out_unknown, 1'b0);
    reset_n = 1'b1;
    #1;
    chk("post_rst_in_ready", in_ready, 1'b1);
    chk("post_rst_ready64", in_ready64, 1'b1);

    // Directed table, XLEN=32: one push per cycle, each result visible one cycle later
    @(negedge clock);
    for (int i = 0; i < 17; i++) begin
      in_valid = 1'b1; in_inst = tv32[i].inst; in_tag = i; out_ready = 1'b1;
      @(posedge clock);
      @(negedge clock);
      chk("t32_valid", out_valid, 1'b1);
      chk("t32_imm", out_imm, tv32[i].imm[31:0]);
      chk("t32_fmt", out_fmt, tv32[i].fmt);
      chk("t32_unknown", out_unknown, tv32[i].unk);
      chk("t32_tag", out_tag, i);
    end
    in_valid = 1'b0;
    @(posedge clock);
    @(negedge clock);
    chk("t32_drained", out_valid, 1'b0);

    // Directed table, XLEN=64
    for (int i = 0; i < 7; i++) begin
      in_valid64 = 1'b1; in_inst64 = tv64[i].inst; in_tag64 = 8'(i + 100); out_ready64 = 1'b1;
      @(posedge clock);
      @(negedge clock);
      chk("t64_valid", out_valid64, 1'b1);
      chk("t64_imm", out_imm64, tv64[i].imm);
      chk("t64_fmt", out_fmt64, tv64[i].fmt);
      chk("t64_unknown", out_unknown64, tv64[i].unk);
      chk("t64_tag", out_tag64, 8'(i + 100));
    end
    in_valid64 = 1'b0;
    @(posedge clock);
    @(negedge clock);
    chk("t64_drained", out_valid64, 1'b0);

    // Backpressure: A and B fill the queue, C is held until a slot frees
    cyc(1'b1, 32'h00500093, 32'd10, 1'b0, 1'b0);
    cyc(1'b1, 32'hFE112E23, 32'd11, 1'b0, 1'b0);
    chk("bp_full_ready", in_ready, 1'b0);
    chk("bp_head_a", out_tag, 32'd10);
    cyc(1'b1, 32'h0080006F, 32'd12, 1'b1, 1'b0);
    chk("bp_head_b", out_tag, 32'd11);
    chk("bp_ready_back", in_ready, 1'b1);
    cyc(1'b1, 32'h0080006F, 32'd12, 1'b1, 1'b0);
    chk("bp_head_c", out_tag, 32'd12);
    chk("bp_head_c_imm", out_imm, 32'd8);
    cyc(1'b0, 32'h0, 32'd0, 1'b1, 1'b0);
    chk("bp_empty", out_valid, 1'b0);

    // Flush with two entries queued and a same-cycle offer
    cyc(1'b1, 32'h00100093, 32'd20, 1'b0, 1'b0);
    cyc(1'b1, 32'h00200093, 32'd21, 1'b0, 1'b0);
    cyc(1'b1, 32'h00300093, 32'd22, 1'b0, 1'b1);
    chk("fl_valid", out_valid, 1'b0);
    chk("fl_ready", in_ready, 1'b1);
    cyc(1'b1, 32'h00400093, 32'd23, 1'b1, 1'b0);
    chk("fl_next_valid", out_valid, 1'b1);
    chk("fl_next_tag", out_tag, 32'd23);
    chk("fl_next_imm", out_imm, 32'd4);
    cyc(1'b0, 32'h0, 32'd0, 1'b1, 1'b0);

    // Reset mid-stream with two entries queued
    cyc(1'b1, 32'hFFF00093, 32'd30, 1'b0, 1'b0);
    cyc(1'b1, 32'hFE000CE3, 32'd31, 1'b0, 1'b0);
    in_valid = 1'b0;
    reset_n  = 1'b0;
    #1;
    chk("mrst_ready_low", in_ready, 1'b0);
    @(posedge clock);
    @(negedge clock);
    chk("mrst_valid", out_valid, 1'b0);
    chk("mrst_imm", out_imm, 32'h0);
    chk("mrst_fmt", out_fmt, 3'd0);
    chk("mrst_tag", out_tag, 32'h0);
    chk("mrst_unknown", out_unknown, 1'b0);
    chk("mrst_ready_held", in_ready, 1'b0);
    mq.delete();
    reset_n = 1'b1;
    #1;
    chk("mrst_ready_high", in_ready, 1'b1);
    @(negedge clock);
    repeat (3) cyc(1'b0, 32'h0, 32'd0, 1'b1, 1'b0);

    // Randomized traffic against the reference model
    for (int n = 0; n < 600; n++) begin
      logic [31:0] r;
      r      = $urandom();
      r[6:0] = ops[$urandom_range(0, 14)];
      if ($urandom_range(0, 9) == 0) r[6:0] = 7'($urandom());
      cyc($urandom_range(0, 9) < 7, r, $urandom(), $urandom_range(0, 9) < 6,
          $urandom_range(0, 24) == 0);
    end
    repeat (3) cyc(1'b0, 32'h0, 32'd0, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
